// File: rtl/dl_div_if.sv
// dl_div_if: operand/result handshake bundle for the DLfloat16 divider.
//   a, b            : dividend / divisor, DLfloat16 (1 sign, 6 exp bias 31, 9 mantissa)
//   ena             : opcode; only the divider's opcode starts an operation
//   in_valid/ready  : operand handshake (ready only while the divider is idle)
//   c_div           : quotient, DLfloat16
//   exception_flags : {invalid, inexact, overflow, underflow, div_zero}
//   out_valid/ready : result handshake
interface dl_div_if;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  ena;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] c_div;
  logic [4:0]  exception_flags;
  logic        out_valid;
  logic        out_ready;

  // Issuing side (FPU issue mux / testbench)
  modport master (
    output a, b, ena, in_valid, out_ready,
    input  in_ready, c_div, exception_flags, out_valid
  );

  // Divider side
  modport slave (
    input  a, b, ena, in_valid, out_ready,
    output in_ready, c_div, exception_flags, out_valid
  );
endinterface

// File: rtl/dl_div.sv
// dl_div: iterative DLfloat16 divider, c_div = a / b, restoring division with
// one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dl_div_if.slave (operands, opcode, result, flags, valid/ready)
// Parameters:
//   OP_CODE : ena value that selects division
//   QBITS   : quotient bits generated (11..16); bits below the 9-bit mantissa
//             are guard bits feeding inexact (and rounding when enabled)
// Optional feature macro: DL_DIV_RNE_EN
//   defined   -> round-to-nearest-even on the normalized quotient
//   undefined -> truncation
// Latency: special operands 1 cycle, normal operands QBITS+2 cycles.
module dl_div #(
  parameter logic [3:0]  OP_CODE = 4'b0011,
  parameter int unsigned QBITS   = 12
) (
  input  logic     clk,
  input  logic     rst,
  dl_div_if.slave  bus
);

  localparam int unsigned MW   = 9;          // stored mantissa bits
  localparam int unsigned EW   = 6;          // exponent bits
  localparam int unsigned SW   = MW + 1;     // significand incl. hidden one
  localparam int unsigned RW   = SW + 1;     // partial remainder
  localparam int unsigned CW   = 5;          // iteration counter
  localparam int unsigned FW   = 5;          // flag vector
  localparam int unsigned PAD  = 16 - QBITS; // left-align quotient into 16 bits

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [14:0]       SAT_MAG  = 15'h7DFE;
  localparam logic signed [7:0] BIAS     = 8'sd31;
  localparam logic [CW-1:0]     CNT_LAST = CW'(QBITS - 1);

  localparam logic [FW-1:0] FLG_INVALID = 5'b10000;
  localparam logic [FW-1:0] FLG_DIV0    = 5'b00001;
  localparam logic [FW-1:0] FLG_OVF     = 5'b01100;  // overflow + inexact
  localparam logic [FW-1:0] FLG_UNF     = 5'b01010;  // underflow + inexact
  localparam logic [FW-1:0] FLG_INEXACT = 5'b01000;

  // State and datapath registers
  logic [1:0]       state_q, state_d;
  logic             s_q, s_d;
  logic [EW-1:0]    ea_q, ea_d;
  logic [EW-1:0]    eb_q, eb_d;
  logic [SW-1:0]    mb_q, mb_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [QBITS-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Registered outputs
  logic [15:0]      c_div_q, c_div_d;
  logic [FW-1:0]    flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  // Special-operand decode on the live inputs (used only at accept)
  logic             spec_hit;
  logic [15:0]      spec_res;
  logic [FW-1:0]    spec_flags;

  // One restoring-division step
  logic             rem_ge;
  logic [SW-1:0]    rem_sub;
  logic [RW-1:0]    rem_next;

  // Normalization / result assembly
  logic [15:0]       qw;
  logic [MW-1:0]     mant_t;
  logic [MW-1:0]     mant_f;
  logic signed [7:0] exp_t;
  logic signed [7:0] exp_f;
  logic              rnd_bit;
  logic              stk_q;
  logic              sticky;
  logic              inexact;
  logic [15:0]       norm_res;
  logic [FW-1:0]     norm_flags;
`ifdef DL_DIV_RNE_EN
  logic              rnd_up;
  logic [MW:0]       mant_inc;
`endif

  // Special cases, checked in priority order
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (bus.a == 16'hFFFF || bus.b == 16'hFFFF) begin
      spec_res   = 16'hFFFF;
      spec_flags = FLG_INVALID;
    end else if (bus.a == 16'h0000 && bus.b == 16'h0000) begin
      spec_res   = 16'hFFFF;
      spec_flags = FLG_INVALID;
    end else if (bus.b == 16'h0000) begin
      spec_res   = {bus.a[15] ^ bus.b[15], SAT_MAG};
      spec_flags = FLG_DIV0;
    end else if (bus.a == 16'h0000) begin
      spec_res   = 16'h0000;
      spec_flags = '0;
    end else begin
      spec_hit   = 1'b0;
    end
  end

  // Restoring step: remainder stays below 2*mb, so it never needs more than RW bits
  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_sub  = SW'(rem_q - {1'b0, mb_q});
    rem_next = rem_ge ? {rem_sub, 1'b0} : {rem_q[SW-1:0], 1'b0};
  end

  // Normalize the quotient and assemble the finite/overflow/underflow result
  always_comb begin
    qw = 16'(q_q) << PAD;
    if (qw[15]) begin
      mant_t  = qw[14:6];
      rnd_bit = qw[5];
      stk_q   = |qw[4:0];
      exp_t   = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS;
    end else begin
      mant_t  = qw[13:5];
      rnd_bit = qw[4];
      stk_q   = |qw[3:0];
      exp_t   = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + BIAS - 8'sd1;
    end
    // Non-zero final remainder means the true quotient has more bits below
    sticky  = stk_q | (|rem_q);
    inexact = rnd_bit | sticky;

`ifdef DL_DIV_RNE_EN
    rnd_up   = rnd_bit & (sticky | mant_t[0]);
    mant_inc = (MW+1)'(mant_t) + (MW+1)'(rnd_up);
    mant_f   = mant_inc[MW-1:0];
    // Carry out of the mantissa bumps the exponent; mantissa wraps to zero
    exp_f    = mant_inc[MW] ? exp_t + 8'sd1 : exp_t;
`else
    mant_f   = mant_t;
    exp_f    = exp_t;
`endif

    if (exp_f <= 8'sd0) begin
      norm_res   = 16'h0000;
      norm_flags = FLG_UNF;
    end else if (exp_f >= 8'sd63) begin
      norm_res   = {s_q, SAT_MAG};
      norm_flags = FLG_OVF;
    end else begin
      norm_res   = {s_q, exp_f[EW-1:0], mant_f};
      norm_flags = inexact ? FLG_INEXACT : '0;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    ea_d        = ea_q;
    eb_d        = eb_q;
    mb_d        = mb_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    c_div_d     = c_div_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        // in_ready is high whenever the state is IDLE
        if (bus.in_valid && bus.ena == OP_CODE) begin
          s_d   = bus.a[15] ^ bus.b[15];
          ea_d  = bus.a[14:9];
          eb_d  = bus.b[14:9];
          mb_d  = {1'b1, bus.b[8:0]};
          rem_d = {2'b01, bus.a[8:0]};
          q_d   = '0;
          cnt_d = '0;
          if (spec_hit) begin
            c_div_d     = spec_res;
            flags_d     = spec_flags;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d     = CALC;
          end
        end
      end
      CALC: begin
        // Quotient bits enter MSB-first; first bit is the integer bit
        q_d   = {q_q[QBITS-2:0], rem_ge};
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = NORM;
        end
      end
      NORM: begin
        c_div_d     = norm_res;
        flags_d     = norm_flags;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      ea_q        <= '0;
      eb_q        <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      c_div_q     <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      ea_q        <= ea_d;
      eb_q        <= eb_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      c_div_q     <= c_div_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.c_div           = c_div_q;
  assign bus.exception_flags = flags_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.in_ready        = in_ready_q;

endmodule

// File: doc/dl_div.md
Name: dl_div

Overview:
- Iterative DLfloat16 divider: computes c_div = a / b.
- Companion of the FPU's combinational-core multiplier: same operand format (1 sign, 6 exp bias 31, 9 mantissa, hidden 1), same opcode-gated issue, same special-value and saturation conventions, same 5-bit flag vector.
- Restoring division: one quotient bit per clock.
- Valid/ready handshake on input and output, so it can sit behind the FPU issue mux.

Parameters:
- OP_CODE, 4'b0011, ena value that selects division; other values never start an operation.
- QBITS, 12, quotient bits generated (legal range 11..16; bits beyond the 9-bit mantissa are guard bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  16  dividend, DLfloat16
- b  input  16  divisor, DLfloat16
- ena  input  4  opcode; operation accepted only when ena==OP_CODE
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  high only in IDLE
- c_div  output  16  result, DLfloat16
- exception_flags  output  5  {invalid, inexact, overflow, underflow, div_zero}
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts result

Behaviour:
- Reset (rst high at a clk edge, any state): state=IDLE, c_div=0, exception_flags=0, out_valid=0, internal regs cleared, in-flight op discarded; in_ready=1 from the next cycle.
- Accept: in_valid & in_ready & ena==OP_CODE at an edge; latch sa, sb, ea, eb, ma={1,a[8:0]}, mb={1,b[8:0]}. If ena!=OP_CODE, nothing is latched and the block stays IDLE.
- States: IDLE -> CALC (normal) or IDLE -> DONE (special); CALC -> NORM after QBITS cycles; NORM -> DONE; DONE -> IDLE when out_ready.
- Special cases, decided at accept (checked in order), go straight to DONE with latency 1:
  - a or b == 16'hFFFF: 16'hFFFF, invalid.
  - a==0 and b==0: 16'hFFFF, invalid.
  - b==0: saturate {sa^sb, 15'h7DFE}, div_zero.
  - a==0: 16'h0000, no flags.
- CALC: rem (11 bits) init ma. Each cycle: if rem>=mb, q bit=1 and rem-=mb, else q bit=0; then rem<<=1. Bits shift into q MSB-first; q[QBITS-1] is the integer bit.
- NORM:
  - If q[QBITS-1]=1: mant=q[QBITS-2 -: 9], e=ea-eb+31.
  - Else: mant=q[QBITS-3 -: 9], e=ea-eb+30.
  - e is computed signed, 8 bits.
  - e<=0: 16'h0000, underflow.
  - e>=63: {s,15'h7DFE}, overflow.
  - Otherwise {s, e[5:0], mant} with s=sa^sb.
  - inexact = OR(discarded q bits) | (final rem!=0). inexact is also set on overflow/underflow results.
- Latency: special = out_valid 1 cycle after the accept cycle; normal = QBITS+2 cycles (14 default). Throughput one op in flight; in_ready low in CALC/NORM/DONE.
- DONE: out_valid=1; c_div and exception_flags held stable until out_ready. out_valid drops on the next edge after out_ready is sampled high. in_valid in DONE is not accepted even if out_ready is high in the same cycle.
- c_div and exception_flags retain the last result after out_valid drops, until the next result or reset.

Optional Feature:
- DL_DIV_RNE_EN defined: round-to-nearest-even using the first discarded bit (round) plus the OR of the remaining discarded bits and rem!=0 (sticky).
  - Mantissa carry-out sets mant=0 and e=e+1.
  - Overflow/underflow are checked after rounding; inexact is unchanged in definition.
- Undefined: truncation only.

Test Plan:
- 6.0/2.0: a=16'h4300, b=16'h4000, ena=4'b0011 -> c_div=16'h4100, flags=5'b00000, out_valid 14 cycles after accept.
- 1.0/3.0: a=16'h3E00, b=16'h4100 -> 16'h3AAA, inexact=1 (flags 5'b01000); with DL_DIV_RNE_EN -> 16'h3AAB.
- Specials:
  - 16'h4000/16'h0000 -> 16'h7DFE, flags 5'b00001.
  - 16'hC000/16'h0000 -> 16'hFDFE, flags 5'b00001.
  - 0/0 -> 16'hFFFF, flags 5'b10000.
  - 16'hFFFF/16'h3E00 -> 16'hFFFF, flags 5'b10000.
  - All with latency 1.
- Range:
  - 16'h0200/16'h7C00 -> 16'h0000, flags 5'b01010.
  - 16'hFC00/16'h0200 -> 16'hFDFE, flags 5'b01100.
- Handshake:
  - ena=4'b0010 with in_valid -> no accept, in_ready stays 1.
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and c_div stable; second in_valid not accepted until IDLE.
- Reset mid-CALC (cycle 5) -> next cycle in_ready=1, out_valid=0, c_div=0; a fresh 6.0/2.0 then completes correctly.
